// File: rtl/spi_mem_arb_pkg.sv
// spi_mem_arb_pkg: shared state encoding and owner constants for the SPI memory arbiter
package spi_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating wait counter flagging when port B has waited MAX_WAIT cycles
module arb_starve_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [7:0] cnt;
  assign at_max = cnt == 8'(MAX_WAIT);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 8'd1;
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: fixed-priority two-port arbiter for the SPI data memory with starvation override for port B
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  owner
);
  state_t state, state_nxt;
  logic lat_we, lat_we_nxt, elig_a, elig_b, grant, win_b, at_max, b_inflight;
  logic a_ack_nxt, b_ack_nxt, mem_we_nxt, busy_nxt, owner_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_din_nxt, a_rdata_nxt, b_rdata_nxt;
  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk),
    .rst(reset),
    .inc(b_req && !(grant && win_b) && !b_inflight),
    .clr(!b_req || (grant && win_b)),
    .at_max(at_max)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      lat_we <= 1'b0;
      owner <= OWNER_A;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_we <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      lat_we <= lat_we_nxt;
      owner <= owner_nxt;
      a_ack <= a_ack_nxt;
      b_ack <= b_ack_nxt;
      a_rdata <= a_rdata_nxt;
      b_rdata <= b_rdata_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din <= mem_din_nxt;
      mem_we <= mem_we_nxt;
      busy <= busy_nxt;
    end
  always_comb begin
    elig_a = a_req && !a_ack && !(state == WAIT && owner == OWNER_A);
    elig_b = b_req && !b_ack && !(state == WAIT && owner == OWNER_B);
    win_b = elig_b && (at_max || !elig_a);
    grant = state != ISSUE && (elig_a || elig_b);
    state_nxt = state == ISSUE ? WAIT : grant ? ISSUE : IDLE;
  end
  always_comb begin
    b_inflight = owner == OWNER_B && state != IDLE;
    owner_nxt = grant ? win_b : owner;
    lat_we_nxt = grant ? (win_b ? b_we : a_we) : lat_we;
    mem_we_nxt = grant && (win_b ? b_we : a_we);
    mem_addr_nxt = grant ? (win_b ? b_addr : a_addr) : mem_addr;
    mem_din_nxt = grant ? (win_b ? b_wdata : a_wdata) : mem_din;
    a_ack_nxt = state == WAIT && owner == OWNER_A;
    b_ack_nxt = state == WAIT && owner == OWNER_B;
    a_rdata_nxt = a_ack_nxt && !lat_we ? mem_dout : a_rdata;
    b_rdata_nxt = b_ack_nxt && !lat_we ? mem_dout : b_rdata;
    busy_nxt = state_nxt != IDLE;
  end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed and randomized self-checking bench against a shadow-memory reference
module tb_spi_mem_arbiter;
  logic clk = 1'b0, reset;
  logic a_req, a_we, a_ack, b_req, b_we, b_ack, mem_we, busy, owner;
  logic [6:0] a_addr, b_addr, mem_addr;
  logic [7:0] a_wdata, a_rdata, b_wdata, b_rdata, mem_din, mem_dout;
  logic [7:0] mem [128] = '{default: 8'h00};
  logic [7:0] shadow [128] = '{default: 8'h00};
  int errors = 0, checks = 0, we_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
  end
  spi_mem_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .MAX_WAIT(1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .owner(owner)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    int a_wait, b_wait, wr_acks, we_base;
    reset = 1'b1;
    {a_req, a_we, b_req, b_we} = '0;
    {a_addr, b_addr} = '0;
    {a_wdata, b_wdata} = '0;
    repeat (3) step();
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    reset = 1'b0;
    step();
    a_req = 1; a_we = 1; a_addr = 7'h05; a_wdata = 8'hA5;
    step();
    check("wr_issue_we", mem_we, 1);
    check("wr_issue_addr", mem_addr, 7'h05);
    check("wr_issue_din", mem_din, 8'hA5);
    check("wr_issue_busy", busy, 1);
    check("wr_issue_owner", owner, 0);
    step();
    check("wr_wait_we", mem_we, 0);
    check("wr_wait_ack", a_ack, 0);
    check("wr_wait_busy", busy, 1);
    step();
    check("wr_ack", a_ack, 1);
    check("wr_ack_busy", busy, 0);
    a_req = 0; shadow[5] = 8'hA5;
    step();
    a_req = 1; a_we = 0;
    step();
    check("rd_issue_we", mem_we, 0);
    step();
    check("rd_wait_ack", a_ack, 0);
    step();
    check("rd_ack", a_ack, 1);
    check("rd_data", a_rdata, 8'hA5);
    a_req = 0;
    step();
    b_req = 1; b_we = 1; b_addr = 7'h10; b_wdata = 8'h3C;
    step();
    check("raw_b_owner", owner, 1);
    check("raw_b_we", mem_we, 1);
    a_req = 1; a_we = 0; a_addr = 7'h10;
    step();
    step();
    check("raw_b_ack", b_ack, 1);
    check("raw_a_owner", owner, 0);
    check("raw_a_addr", mem_addr, 7'h10);
    check("raw_a_we", mem_we, 0);
    b_req = 0; shadow[7'h10] = 8'h3C;
    step();
    check("raw_a_wait", a_ack, 0);
    step();
    check("raw_a_ack", a_ack, 1);
    check("raw_a_data", a_rdata, 8'h3C);
    a_req = 0;
    step();
    a_req = 1; a_we = 0; a_addr = 7'h05;
    b_req = 1; b_we = 0; b_addr = 7'h10;
    step();
    check("cont_owner_a", owner, 0);
    check("cont_addr_a", mem_addr, 7'h05);
    step();
    step();
    check("cont_a_ack", a_ack, 1);
    check("cont_a_data", a_rdata, 8'hA5);
    check("cont_owner_b", owner, 1);
    check("cont_addr_b", mem_addr, 7'h10);
    check("cont_b_early", b_ack, 0);
    a_req = 0;
    step();
    check("cont_b_wait", b_ack, 0);
    step();
    check("cont_b_ack", b_ack, 1);
    check("cont_b_data", b_rdata, 8'h3C);
    b_req = 0;
    step();
    b_req = 1; b_we = 0; b_addr = 7'h05;
    repeat (3) step();
    check("starve_b_ack", b_ack, 1);
    check("starve_b_data", b_rdata, 8'hA5);
    step();
    check("starve_idle", busy, 0);
    a_req = 1; a_we = 0; a_addr = 7'h10;
    step();
    check("starve_owner", owner, 1);
    check("starve_addr", mem_addr, 7'h05);
    repeat (2) step();
    check("starve_b_ack2", b_ack, 1);
    check("starve_a_owner", owner, 0);
    check("starve_a_addr", mem_addr, 7'h10);
    b_req = 0;
    repeat (2) step();
    check("starve_a_ack", a_ack, 1);
    check("starve_a_data", a_rdata, 8'h3C);
    a_req = 0;
    step();
    a_req = 1; a_we = 0; a_addr = 7'h05;
    repeat (3) step();
    check("hold1_ack", a_ack, 1);
    step();
    a_req = 0;
    check("hold1_busy", busy, 0);
    step();
    check("hold1_busy2", busy, 0);
    check("hold1_noack", a_ack, 0);
    step();
    a_req = 1;
    repeat (3) step();
    check("hold2_ack", a_ack, 1);
    step();
    check("hold2_noack", a_ack, 0);
    check("hold2_idle", busy, 0);
    step();
    check("hold2_busy", busy, 1);
    check("hold2_addr", mem_addr, 7'h05);
    step();
    check("hold2_wait", a_ack, 0);
    step();
    check("hold2_ack2", a_ack, 1);
    a_req = 0;
    step();
    a_req = 1; a_we = 1; a_addr = 7'h22; a_wdata = 8'h5A;
    step();
    check("rstmid_we", mem_we, 1);
    reset = 1; a_req = 0;
    step();
    check("rstmid_we_low", mem_we, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ack", a_ack, 0);
    check("rstmid_addr", mem_addr, 0);
    reset = 0;
    step();
    check("rstmid_noack", a_ack, 0);
    check("rstmid_idle", busy, 0);
    shadow[7'h22] = 8'h5A;
    a_req = 1; a_we = 0; a_addr = 7'h22;
    repeat (3) step();
    check("rstmid_rd_ack", a_ack, 1);
    check("rstmid_rd_data", a_rdata, 8'h5A);
    a_req = 0;
    step();
    a_wait = 0; b_wait = 0; wr_acks = 0; we_base = we_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (a_req) begin
        if (a_ack) begin
          check("rnd_a_lat", a_wait <= 12, 1);
          if (a_we) begin shadow[a_addr] = a_wdata; wr_acks++; end
          else check("rnd_a_data", a_rdata, shadow[a_addr]);
          a_req = 0;
        end else if (++a_wait > 12) begin
          check("rnd_a_timeout", a_ack, 1);
          a_req = 0;
        end
      end else if (i < 2950 && $urandom_range(2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(1)); a_addr = 7'($urandom_range(7)); a_wdata = 8'($urandom); a_wait = 0;
      end
      if (b_req) begin
        if (b_ack) begin
          check("rnd_b_lat", b_wait <= 12, 1);
          if (b_we) begin shadow[b_addr] = b_wdata; wr_acks++; end
          else check("rnd_b_data", b_rdata, shadow[b_addr]);
          b_req = 0;
        end else if (++b_wait > 12) begin
          check("rnd_b_timeout", b_ack, 1);
          b_req = 0;
        end
      end else if (i < 2950 && $urandom_range(2) == 0) begin
        b_req = 1; b_we = 1'($urandom_range(1)); b_addr = 7'($urandom_range(7)); b_wdata = 8'($urandom); b_wait = 0;
      end
      step();
    end
    check("rnd_we_pulses", we_cnt - we_base, wr_acks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
